// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - parametrised router channel FIFO with header tags and packet tracking
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int LEN_LSB  = 2,
    parameter int AFULL_TH = 14
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     soft_reset,
    input  logic                     write_enb,
    input  logic                     read_enb,
    input  logic                     lfd_state,
    input  logic [DATA_W-1:0]        data_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     pkt_done,
    output logic                     err_ovf,
    output logic                     err_udf
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int LEN_W  = DATA_W - LEN_LSB;
    localparam int CNT_W  = LEN_W + 1;
    localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_TH);

    logic [DATA_W:0]       mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  lfd_d;
    logic [CNT_W-1:0]      byte_cnt;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [DATA_W:0]       rd_word;
    logic                  rd_hdr;
    logic [LEN_W-1:0]      rd_len;

    // Flags come only from registered pointers, never from the request inputs.
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty       = (wr_ptr == rd_ptr);
    assign fill_count  = wr_ptr - rd_ptr;
    assign almost_full = (fill_count >= AFULL_LVL);

    assign wr_accept = write_enb && !full;
    assign rd_accept = read_enb && !empty;

    assign rd_word = mem[rd_ptr[ADDR_W-1:0]];
    assign rd_hdr  = rd_word[DATA_W];
    assign rd_len  = rd_word[DATA_W-1:LEN_LSB];

    always_ff @(posedge clk) begin
        if (wr_accept && !soft_reset) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_d, data_in};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lfd_d      <= 1'b0;
            byte_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            err_ovf    <= 1'b0;
            err_udf    <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            lfd_d      <= 1'b0;
            byte_cnt   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            err_ovf    <= 1'b0;
            err_udf    <= 1'b0;
        end else begin
            lfd_d      <= lfd_state;
            data_valid <= rd_accept;
            pkt_done   <= 1'b0;

            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            // A blocked half of a simultaneous request is not an error.
            if (write_enb && full && !read_enb) begin
                err_ovf <= 1'b1;
            end
            if (read_enb && empty && !write_enb) begin
                err_udf <= 1'b1;
            end

            if (rd_accept) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= rd_word[DATA_W-1:0];
                // A header always restarts the count, truncating any packet in flight.
                if (rd_hdr) begin
                    byte_cnt <= {1'b0, rd_len} + CNT_W'(1);
                end else if (byte_cnt != '0) begin
                    byte_cnt <= byte_cnt - CNT_W'(1);
                    pkt_done <= (byte_cnt == CNT_W'(1));
                end
            end
        end
    end

endmodule
